// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  // funct3 encodings for RV32I loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic size_t f3_size(input logic [2:0] funct3);
    return size_t'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response handshake bundle between core and data memory
interface dmem_if;
  import dmem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  size_t       req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for sub-word stores and load extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = raw_word[{addr_lo, 3'b000} +: 8];
  assign sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

  // Store data is replicated across lanes; byte_en picks which lanes land.
  always_comb begin
    byte_en    = 4'b0000;
    store_word = 32'h0;
    load_data  = 32'h0;
    misalign   = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{wdata[7:0]}};
        load_data  = {{24{sel_byte[7] & ~load_unsigned}}, sel_byte};
      end
      SZ_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{wdata[15:0]}};
        load_data  = {{16{sel_half[15] & ~load_unsigned}}, sel_half};
        misalign   = addr_lo[0];
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        store_word = wdata;
        load_data  = raw_word;
        misalign   = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory with fixed access latency
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int LAT_C = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_C - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              ready;
  logic              accept;
  logic              do_access;
  logic              commit;

  logic              lat_write;
  logic              lat_unsigned;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  size_t             lat_size;

  logic              a_write;
  logic              a_unsigned;
  logic [31:0]       a_addr;
  logic [31:0]       a_wdata;
  size_t             a_size;
  logic [AW-1:0]     a_idx;
  logic              range_err;
  logic              acc_err;

  logic [3:0]        byte_en;
  logic [31:0]       store_word;
  logic [31:0]       load_data;
  logic [31:0]       raw_word;
  logic              misalign;

  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0]       mem [DEPTH_WORDS];

  assign accept = bus.req_valid && ready;

  // The access happens on the edge that enters RESP; with unit latency that
  // is the acceptance edge itself, so the live bus feeds the datapath.
  assign do_access = (accept && (LAT_C == 1)) || ((state == WAIT) && (cnt == CNT_W'(1)));

  assign a_write    = (state == IDLE) ? bus.req_write    : lat_write;
  assign a_unsigned = (state == IDLE) ? bus.req_unsigned : lat_unsigned;
  assign a_addr     = (state == IDLE) ? bus.req_addr     : lat_addr;
  assign a_wdata    = (state == IDLE) ? bus.req_wdata    : lat_wdata;
  assign a_size     = (state == IDLE) ? bus.req_size     : lat_size;

  assign a_idx     = a_addr[AW+1:2];
  assign range_err = a_addr[31:2] >= 30'(DEPTH_WORDS);
  assign acc_err   = range_err || misalign || (a_size == SZ_ILL);
  assign commit    = do_access && a_write && !acc_err;
  assign raw_word  = mem[a_idx];

  dmem_lane_align u_align (
    .size          (a_size),
    .addr_lo       (a_addr[1:0]),
    .load_unsigned (a_unsigned),
    .wdata         (a_wdata),
    .raw_word      (raw_word),
    .byte_en       (byte_en),
    .store_word    (store_word),
    .load_data     (load_data),
    .misalign      (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LAT_C == 1) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready         = (state == IDLE) && rst_n;
    bus.req_ready = ready;
    bus.rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      lat_size     <= SZ_BYTE;
    end else if (accept) begin
      cnt          <= CNT_LOAD;
      lat_write    <= bus.req_write;
      lat_unsigned <= bus.req_unsigned;
      lat_addr     <= bus.req_addr;
      lat_wdata    <= bus.req_wdata;
      lat_size     <= bus.req_size;
    end else if (state == WAIT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else if (do_access) begin
      rsp_rdata_q <= (a_write || acc_err) ? 32'h0 : load_data;
      rsp_err_q   <= acc_err;
    end
  end

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Storage is deliberately not reset; only committed, error-free stores land.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[a_idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

endmodule
